// File: rtl/ppu_compositor.sv
// ppu_compositor
//   Merges the background layer with NUM_SPR_CH sprite channels.
//   Resolves transparency, left-edge clipping and priority, then looks up the
//   system colour in a 32-entry palette RAM. Also latches the sprite-0 hit and
//   owns the CPU palette port.
//
//   Pixel path is two clocks deep and accepts a pixel every cycle:
//     S1: opacity/priority resolve, palette address registered
//     S2: palette lookup registered into sys_idx_out, valid_out pulses
//
// Ports
//   clk_in, nrst_in        clock, synchronous active-low reset
//   pix_pulse_in           pixel inputs valid this cycle
//   frame_start_in         clears the sprite-0 hit flag
//   x_in                   pixel x
//   bg_en_in, spr_en_in    layer enables
//   clip_bg_in/spr_in      hide layer when x_in < CLIP_W
//   bg_idx_in              background {palette, pixel}
//   spr_idx_in             per-channel {palette, pixel}, channel k at [4k+3:4k]
//   spr_pri_in             per-channel 1 = behind background
//   spr0_in                channel 0 is currently showing sprite 0
//   pram_a/d/wr_in         CPU palette address / write data / write strobe
//   pram_d_out             CPU palette read data, 1-cycle latency
//   sys_idx_out            system palette index to the VGA stage
//   valid_out              sys_idx_out updated this cycle
//   spr0_hit_out           sticky sprite-0 hit
//
// Optional build macro PPU_COMP_GREYSCALE_EN adds greyscale_in; while high,
// sys_idx_out and pram_d_out are masked with 6'h30 as they are loaded.

module ppu_compositor #(
    parameter int NUM_SPR_CH = 2,
    parameter int PAL_W      = 6,
    parameter int CLIP_W     = 8
) (
    input  logic                    clk_in,
    input  logic                    nrst_in,
    input  logic                    pix_pulse_in,
    input  logic                    frame_start_in,
    input  logic [7:0]              x_in,
    input  logic                    bg_en_in,
    input  logic                    spr_en_in,
    input  logic                    clip_bg_in,
    input  logic                    clip_spr_in,
    input  logic [3:0]              bg_idx_in,
    input  logic [4*NUM_SPR_CH-1:0] spr_idx_in,
    input  logic [NUM_SPR_CH-1:0]   spr_pri_in,
    input  logic                    spr0_in,
    input  logic [4:0]              pram_a_in,
    input  logic [PAL_W-1:0]        pram_d_in,
    input  logic                    pram_wr_in,
`ifdef PPU_COMP_GREYSCALE_EN
    input  logic                    greyscale_in,
`endif
    output logic [PAL_W-1:0]        pram_d_out,
    output logic [PAL_W-1:0]        sys_idx_out,
    output logic                    valid_out,
    output logic                    spr0_hit_out
);

    localparam int STAGES = 2;

    // Sprite-palette entry 0 of each group aliases the matching background
    // entry, so 0x10/14/18/1C land on 0x00/04/08/0C.
    function automatic logic [4:0] pal_mirror(input logic [4:0] a);
        return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

    logic [PAL_W-1:0]             r_pram [0:31];
    logic [PAL_W-1:0]             r_pram_d;
    logic [PAL_W-1:0]             r_sys_idx;
    logic [4:0]                   r_s1_addr;
    logic [STAGES:1]              r_vld_pipe;
    logic                         r_spr0_hit;

    logic [NUM_SPR_CH-1:0][3:0]   w_spr_idx;
    logic [NUM_SPR_CH-1:0]        w_spr_op;
    logic                         w_in_clip;
    logic                         w_bg_op;
    logic                         w_win_found;
    logic [3:0]                   w_win_idx;
    logic                         w_win_pri;
    logic [4:0]                   w_addr;
    logic [4:0]                   w_cpu_addr;
    logic                         w_hit_set;
    logic [PAL_W-1:0]             w_grey_mask;

    assign w_spr_idx  = spr_idx_in;
    assign w_cpu_addr = pal_mirror(pram_a_in);

    // 9-bit compare so a CLIP_W of 256 still covers the whole line.
    assign w_in_clip = ({1'b0, x_in} < 9'(CLIP_W));
    assign w_bg_op   = bg_en_in & (|bg_idx_in[1:0]) & ~(clip_bg_in & w_in_clip);

    for (genvar k = 0; k < NUM_SPR_CH; k++) begin : g_ch
        assign w_spr_op[k] = spr_en_in & (|w_spr_idx[k][1:0]) & ~(clip_spr_in & w_in_clip);
    end

    // Lowest opaque channel wins outright, even when it sits behind the
    // background: a behind-bg winner still hides higher-index channels.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = 4'h0;
        w_win_pri   = 1'b0;
        for (int k = NUM_SPR_CH - 1; k >= 0; k--) begin
            if (w_spr_op[k]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_spr_idx[k];
                w_win_pri   = spr_pri_in[k];
            end
        end
    end

    always_comb begin
        w_addr = 5'h00;
        if (w_win_found && (!w_win_pri || !w_bg_op))
            w_addr = {1'b1, w_win_idx};
        else if (w_bg_op)
            w_addr = {1'b0, bg_idx_in};
    end

    assign w_hit_set = pix_pulse_in & spr0_in & w_spr_op[0] & w_bg_op & (x_in != 8'hFF);

`ifdef PPU_COMP_GREYSCALE_EN
    assign w_grey_mask = greyscale_in ? PAL_W'(6'h30) : {PAL_W{1'b1}};
`else
    assign w_grey_mask = {PAL_W{1'b1}};
`endif

    // Reads use the pre-write contents, so a same-cycle CPU write or a
    // same-cycle pixel lookup of the written entry both see old data.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            for (int i = 0; i < 32; i++) r_pram[i] <= '0;
            r_pram_d   <= '0;
            r_sys_idx  <= '0;
            r_s1_addr  <= '0;
            r_vld_pipe <= '0;
            r_spr0_hit <= 1'b0;
        end else begin
            if (pram_wr_in) r_pram[w_cpu_addr] <= pram_d_in;
            r_pram_d <= r_pram[w_cpu_addr] & w_grey_mask;

            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], pix_pulse_in};
            if (pix_pulse_in)  r_s1_addr <= w_addr;
            if (r_vld_pipe[1]) r_sys_idx <= r_pram[pal_mirror(r_s1_addr)] & w_grey_mask;

            if (frame_start_in) r_spr0_hit <= 1'b0;
            else if (w_hit_set) r_spr0_hit <= 1'b1;
        end
    end

    assign pram_d_out   = r_pram_d;
    assign sys_idx_out  = r_sys_idx;
    assign valid_out    = r_vld_pipe[STAGES];
    assign spr0_hit_out = r_spr0_hit;

endmodule

// File: tb/tb_ppu_compositor.sv
module tb_ppu_compositor;

    logic       clk = 1'b0;
    logic       nrst;
    logic       pix_pulse, frame_start;
    logic [7:0] x;
    logic       bg_en, spr_en, clip_bg, clip_spr;
    logic [3:0] bg_idx;
    logic [7:0] spr_idx;
    logic [1:0] spr_pri;
    logic       spr0;
    logic [4:0] pram_a;
    logic [5:0] pram_d;
    logic       pram_wr;
    logic [5:0] pram_q, sys_idx;
    logic       valid, hit;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ppu_compositor #(.NUM_SPR_CH(2), .PAL_W(6), .CLIP_W(8)) dut (
        .clk_in(clk), .nrst_in(nrst), .pix_pulse_in(pix_pulse),
        .frame_start_in(frame_start), .x_in(x), .bg_en_in(bg_en),
        .spr_en_in(spr_en), .clip_bg_in(clip_bg), .clip_spr_in(clip_spr),
        .bg_idx_in(bg_idx), .spr_idx_in(spr_idx), .spr_pri_in(spr_pri),
        .spr0_in(spr0), .pram_a_in(pram_a), .pram_d_in(pram_d),
        .pram_wr_in(pram_wr), .pram_d_out(pram_q), .sys_idx_out(sys_idx),
        .valid_out(valid), .spr0_hit_out(hit)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [3:0] bg, s0, s1;
        logic [1:0] pri;
        logic       ben, sen, cbg, cspr;
        logic [5:0] exp;
    } pix_t;

    function automatic pix_t mk(input logic [7:0] px, input logic [3:0] bg, s0, s1,
                                input logic [1:0] pri, input logic ben, sen, cbg, cspr,
                                input logic [5:0] exp);
        return '{x: px, bg: bg, s0: s0, s1: s1, pri: pri, ben: ben, sen: sen,
                 cbg: cbg, cspr: cspr, exp: exp};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pwrite(input logic [4:0] a, input logic [5:0] d);
        pram_a = a; pram_d = d; pram_wr = 1'b1;
        tick();
        pram_wr = 1'b0;
    endtask

    // Drive one pixel through S1 only.
    task automatic send_pix(input pix_t p);
        x = p.x; bg_idx = p.bg; spr_idx = {p.s1, p.s0}; spr_pri = p.pri;
        bg_en = p.ben; spr_en = p.sen; clip_bg = p.cbg; clip_spr = p.cspr;
        pix_pulse = 1'b1;
        tick();
        pix_pulse = 1'b0;
    endtask

    // Full pixel: S1 then S2, returning what the output stage shows.
    task automatic drive_pix(input pix_t p, output logic v, output logic [5:0] s);
        send_pix(p);
        tick();
        v = valid;
        s = sys_idx;
    endtask

    task automatic test_reset;
        nrst = 1'b0; pix_pulse = 1'b1; bg_idx = 4'h1;
        tick(); tick();
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (sys_idx !== 6'h0) begin errors++; $display("FAIL reset_sys: got %h want 00", sys_idx); end
        checks++; if (pram_q !== 6'h0)  begin errors++; $display("FAIL reset_pram_q: got %h want 00", pram_q); end
        checks++; if (hit !== 1'b0)     begin errors++; $display("FAIL reset_hit: got %b want 0", hit); end
        pix_pulse = 1'b0; nrst = 1'b1;
        pram_a = 5'h1F;
        tick();
        checks++; if (pram_q !== 6'h0)  begin errors++; $display("FAIL reset_ram1f: got %h want 00", pram_q); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_no_valid: got %b want 0", valid); end
    endtask

    task automatic test_cpu_port;
        pwrite(5'h10, 6'h2C);
        pram_a = 5'h00; tick();
        checks++; if (pram_q !== 6'h2C) begin errors++; $display("FAIL cpu_mirror_rd00: got %h want 2c", pram_q); end
        pram_a = 5'h01; tick();
        checks++; if (pram_q !== 6'h00) begin errors++; $display("FAIL cpu_ram01: got %h want 00", pram_q); end
        pram_a = 5'h10; tick();
        checks++; if (pram_q !== 6'h2C) begin errors++; $display("FAIL cpu_rd10: got %h want 2c", pram_q); end
        pram_a = 5'h03; pram_d = 6'h15; pram_wr = 1'b1; tick();
        pram_wr = 1'b0;
        checks++; if (pram_q !== 6'h00) begin errors++; $display("FAIL cpu_rw_old: got %h want 00", pram_q); end
        tick();
        checks++; if (pram_q !== 6'h15) begin errors++; $display("FAIL cpu_rw_new: got %h want 15", pram_q); end
    endtask

    // Backdrop 0x0F; every other non-aliased entry a holds a+0x20.
    task automatic fill_palette;
        pwrite(5'h00, 6'h0F);
        for (int a = 1; a < 32; a++)
            if (a < 16 || (a % 4) != 0) pwrite(5'(a), 6'(a + 32));
    endtask

    task automatic test_priority;
        pix_t       v [3];
        logic       ov;
        logic [5:0] os;
        v[0] = mk(8'd20, 4'h5, 4'h6, 4'h0, 2'b00, 1, 1, 0, 0, 6'h36);
        v[1] = mk(8'd20, 4'h5, 4'h6, 4'h0, 2'b01, 1, 1, 0, 0, 6'h25);
        v[2] = mk(8'd20, 4'h4, 4'h6, 4'h0, 2'b01, 1, 1, 0, 0, 6'h36);
        for (int i = 0; i < 3; i++) begin
            drive_pix(v[i], ov, os);
            checks++;
            if ({ov, os} !== {1'b1, v[i].exp})
                begin errors++; $display("FAIL priority[%0d]: got v=%b idx=%h want v=1 idx=%h", i, ov, os, v[i].exp); end
        end
        tick();
        checks++;
        if ({valid, sys_idx} !== {1'b0, 6'h36})
            begin errors++; $display("FAIL priority_hold: got v=%b idx=%h want v=0 idx=36", valid, sys_idx); end
    endtask

    task automatic test_multi_channel;
        pix_t       v [5];
        logic       ov;
        logic [5:0] os;
        v[0] = mk(8'd20, 4'h0, 4'h4, 4'h7, 2'b00, 1, 1, 0, 0, 6'h37);
        v[1] = mk(8'd20, 4'h1, 4'h5, 4'h7, 2'b01, 1, 1, 0, 0, 6'h21);
        v[2] = mk(8'd20, 4'h0, 4'h0, 4'h0, 2'b00, 1, 1, 0, 0, 6'h0F);
        v[3] = mk(8'd20, 4'h2, 4'h6, 4'h0, 2'b00, 1, 0, 0, 0, 6'h22);
        v[4] = mk(8'd20, 4'h2, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 6'h0F);
        for (int i = 0; i < 5; i++) begin
            drive_pix(v[i], ov, os);
            checks++;
            if ({ov, os} !== {1'b1, v[i].exp})
                begin errors++; $display("FAIL multi[%0d]: got v=%b idx=%h want v=1 idx=%h", i, ov, os, v[i].exp); end
        end
    endtask

    task automatic test_clip;
        pix_t       v [5];
        logic       ov;
        logic [5:0] os;
        v[0] = mk(8'd3, 4'h2, 4'h0, 4'h0, 2'b00, 1, 1, 1, 0, 6'h0F);
        v[1] = mk(8'd8, 4'h2, 4'h0, 4'h0, 2'b00, 1, 1, 1, 0, 6'h22);
        v[2] = mk(8'd7, 4'h2, 4'h0, 4'h0, 2'b00, 1, 1, 1, 0, 6'h0F);
        v[3] = mk(8'd7, 4'h0, 4'h6, 4'h0, 2'b00, 1, 1, 0, 1, 6'h0F);
        v[4] = mk(8'd8, 4'h0, 4'h6, 4'h0, 2'b00, 1, 1, 0, 1, 6'h36);
        for (int i = 0; i < 5; i++) begin
            drive_pix(v[i], ov, os);
            checks++;
            if ({ov, os} !== {1'b1, v[i].exp})
                begin errors++; $display("FAIL clip[%0d]: got v=%b idx=%h want v=1 idx=%h", i, ov, os, v[i].exp); end
        end
        clip_bg = 1'b0; clip_spr = 1'b0;
    endtask

    task automatic test_spr0_hit;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        spr0 = 1'b1;
        send_pix(mk(8'd10, 4'h5, 4'h6, 4'h0, 2'b00, 1, 1, 0, 0, 6'h00));
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_set: got %b want 1", hit); end
        tick();
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_sticky: got %b want 1", hit); end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_clear: got %b want 0", hit); end
        send_pix(mk(8'd255, 4'h5, 4'h6, 4'h0, 2'b00, 1, 1, 0, 0, 6'h00));
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_x255: got %b want 0", hit); end
        send_pix(mk(8'd10, 4'h4, 4'h6, 4'h0, 2'b00, 1, 1, 0, 0, 6'h00));
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_bg_clear: got %b want 0", hit); end
        frame_start = 1'b1;
        send_pix(mk(8'd10, 4'h5, 4'h6, 4'h0, 2'b00, 1, 1, 0, 0, 6'h00));
        frame_start = 1'b0;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_fs_wins: got %b want 0", hit); end
        spr0 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        x = 8'd40; bg_en = 1'b1; spr_en = 1'b1; spr_pri = 2'b00;
        bg_idx = 4'h1; spr_idx = 8'h06; spr0 = 1'b1; pix_pulse = 1'b1;
        tick();
        bg_idx = 4'h2; spr_idx = 8'h00; spr0 = 1'b0;
        tick();
        checks++; if ({valid, sys_idx} !== {1'b1, 6'h36}) begin errors++; $display("FAIL b2b_0: got v=%b idx=%h want v=1 idx=36", valid, sys_idx); end
        bg_idx = 4'h3;
        tick();
        checks++; if ({valid, sys_idx} !== {1'b1, 6'h22}) begin errors++; $display("FAIL b2b_1: got v=%b idx=%h want v=1 idx=22", valid, sys_idx); end
        bg_idx = 4'h5;
        tick();
        checks++; if ({valid, sys_idx} !== {1'b1, 6'h23}) begin errors++; $display("FAIL b2b_2: got v=%b idx=%h want v=1 idx=23", valid, sys_idx); end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL b2b_hit: got %b want 1", hit); end
        pram_a = 5'h16;
        nrst = 1'b0; pix_pulse = 1'b0;
        tick();
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL b2b_rst_valid: got %b want 0", valid); end
        checks++; if (sys_idx !== 6'h0) begin errors++; $display("FAIL b2b_rst_sys: got %h want 00", sys_idx); end
        checks++; if (hit !== 1'b0)     begin errors++; $display("FAIL b2b_rst_hit: got %b want 0", hit); end
        nrst = 1'b1;
        tick();
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL b2b_no_late_valid: got %b want 0", valid); end
        checks++; if (pram_q !== 6'h0)  begin errors++; $display("FAIL b2b_ram16: got %h want 00", pram_q); end
        pram_a = 5'h00;
        tick();
        checks++; if (pram_q !== 6'h0)  begin errors++; $display("FAIL b2b_ram00: got %h want 00", pram_q); end
    endtask

    initial begin
        nrst = 1'b0; pix_pulse = 1'b0; frame_start = 1'b0; x = 8'd0;
        bg_en = 1'b1; spr_en = 1'b1; clip_bg = 1'b0; clip_spr = 1'b0;
        bg_idx = 4'h0; spr_idx = 8'h00; spr_pri = 2'b00; spr0 = 1'b0;
        pram_a = 5'h00; pram_d = 6'h00; pram_wr = 1'b0;

        test_reset();
        test_cpu_port();
        fill_palette();
        test_priority();
        test_multi_channel();
        test_clip();
        test_spr0_hit();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
